// File: rtl/ds_issue_stage_pkg.sv
// Shared definitions for the decode/issue stage.
// Payload field map, zero register and producer indices.
package ds_issue_stage_pkg;

    localparam int PIPE_PAYLOAD_W = 128;

    localparam int PC_LSB       = 0;
    localparam int PC_W         = 32;
    localparam int IMM_LSB      = 32;
    localparam int IMM_W        = 32;
    localparam int ALU_OP_LSB   = 64;
    localparam int ALU_OP_W     = 12;
    localparam int RF_WE_BIT    = 76;
    localparam int RF_WADDR_LSB = 77;
    localparam int RF_WADDR_W   = 5;
    localparam int MEM_CTRL_LSB = 82;
    localparam int MEM_CTRL_W   = 4;

    localparam int REG_ZERO = 0;

    localparam int FWD_EXE = 0;
    localparam int FWD_MEM = 1;
    localparam int FWD_WB  = 2;

endpackage

// File: rtl/ds_issue_stage_if.sv
// Pipe handshake bundle between IF, the issue stage and EXE.
// slave = issue stage side, master = its environment.
interface ds_issue_stage_if
    import ds_issue_stage_pkg::*;
#(
    parameter int PAYLOAD_W = PIPE_PAYLOAD_W,
    parameter int DATA_W    = 32,
    parameter int NUM_SRC   = 2
);
    logic                      fs_to_ds_valid;
    logic [PAYLOAD_W-1:0]      fs_payload;
    logic                      ds_allowin;
    logic                      ds_to_es_valid;
    logic [PAYLOAD_W-1:0]      ds_payload;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic                      es_allowin;

    modport master (
        output fs_to_ds_valid, fs_payload, es_allowin,
        input  ds_allowin, ds_to_es_valid, ds_payload, src_data
    );

    modport slave (
        input  fs_to_ds_valid, fs_payload, es_allowin,
        output ds_allowin, ds_to_es_valid, ds_payload, src_data
    );
endinterface

// File: rtl/ds_issue_stage_fwd_mux.sv
// Priority forwarding for one source operand.
// Youngest matching producer wins; a match without data is unresolved.
module ds_issue_stage_fwd_mux
    import ds_issue_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_FWD = 3
) (
    input  logic                      used,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         rf_rdata,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
    input  logic [NUM_FWD-1:0]        fwd_data_ok,
    output logic [DATA_W-1:0]         value,
    output logic                      resolved
);

    // scan oldest to youngest so the lowest index overrides
    always_comb begin
        value    = '0;
        resolved = 1'b1;
        if (used && addr != ADDR_W'(REG_ZERO)) begin
            value = rf_rdata;
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (fwd_we[k] &&
                    fwd_waddr[k*ADDR_W +: ADDR_W] == addr) begin
                    value    = fwd_wdata[k*DATA_W +: DATA_W];
                    resolved = fwd_data_ok[k];
                end
            end
        end
    end

endmodule

// File: rtl/ds_issue_stage.sv
// Decode/issue stage: holds one instruction, resolves operands by
// forwarding, stalls on load-use and latches operands under back-pressure.
module ds_issue_stage
    import ds_issue_stage_pkg::*;
#(
    parameter int PAYLOAD_W = PIPE_PAYLOAD_W,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_SRC   = 2,
    parameter int NUM_FWD   = 3,
    parameter int CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    ds_issue_stage_if.slave           pipe,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC-1:0]        src_used,
    input  logic [NUM_SRC*DATA_W-1:0] rf_rdata,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
    input  logic [NUM_FWD-1:0]        fwd_data_ok,
    input  logic                      flush,
    output logic                      hazard_stall,
    output logic [CNT_W-1:0]          stall_cnt
);

    logic                      ds_valid;
    logic [PAYLOAD_W-1:0]      payload_q;
    logic [NUM_SRC-1:0]        hold_valid;
    logic [DATA_W-1:0]         src_hold [NUM_SRC];
    logic [DATA_W-1:0]         mux_val  [NUM_SRC];
    logic [NUM_SRC-1:0]        mux_ok;
    logic [DATA_W-1:0]         res_val  [NUM_SRC];
    logic [NUM_SRC-1:0]        res_ok;
    logic [NUM_SRC*DATA_W-1:0] src_flat;
    logic                      ready_go;
    logic                      accept;
    logic                      leave;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        ds_issue_stage_fwd_mux #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .NUM_FWD (NUM_FWD)
        ) u_mux (
            .used        (src_used[i]),
            .addr        (src_addr[i*ADDR_W +: ADDR_W]),
            .rf_rdata    (rf_rdata[i*DATA_W +: DATA_W]),
            .fwd_we      (fwd_we),
            .fwd_waddr   (fwd_waddr),
            .fwd_wdata   (fwd_wdata),
            .fwd_data_ok (fwd_data_ok),
            .value       (mux_val[i]),
            .resolved    (mux_ok[i])
        );
    end

    // held operands take precedence over live forwarding
    always_comb begin
        src_flat = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            res_ok[i]  = hold_valid[i] | mux_ok[i];
            res_val[i] = hold_valid[i] ? src_hold[i] : mux_val[i];
            src_flat[i*DATA_W +: DATA_W] = res_val[i];
        end
    end

    assign ready_go     = &res_ok;
    assign hazard_stall = ds_valid && !ready_go;

    assign pipe.ds_to_es_valid = ds_valid && ready_go && !flush;
    assign pipe.ds_allowin     = !ds_valid
                               || (ready_go && pipe.es_allowin)
                               || flush;
    assign pipe.ds_payload     = payload_q;
    assign pipe.src_data       = src_flat;

    assign accept = pipe.fs_to_ds_valid && pipe.ds_allowin && !flush;
    assign leave  = pipe.ds_to_es_valid && pipe.es_allowin;

    // stage occupancy: flush beats accept beats leave
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_valid <= 1'b0;
        end else if (flush) begin
            ds_valid <= 1'b0;
        end else if (accept) begin
            ds_valid <= 1'b1;
        end else if (leave) begin
            ds_valid <= 1'b0;
        end
    end

    // payload register loads only on an accepted instruction
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            payload_q <= '0;
        end else if (accept) begin
            payload_q <= pipe.fs_payload;
        end
    end

    // freeze resolved operands while EXE back-pressures
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_valid <= '0;
            for (int i = 0; i < NUM_SRC; i++) src_hold[i] <= '0;
        end else if (flush || leave || accept) begin
            hold_valid <= '0;
        end else if (ds_valid && ready_go && !pipe.es_allowin) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!hold_valid[i]) begin
                    hold_valid[i] <= 1'b1;
                    src_hold[i]   <= res_val[i];
                end
            end
        end
    end

    // saturating count of data-hazard stall cycles
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (hazard_stall && stall_cnt != {CNT_W{1'b1}}) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/ds_issue_stage.md
Name: ds_issue_stage

Overview:
- Parametrised successor to the decode-stage pipeline control and its ID→EXE pipeline register.
- Sits between IF and EXE. Holds one decoded instruction payload under valid/allowin handshake.
- Resolves NUM_SRC register operands by forwarding from NUM_FWD producer stages, and stalls on not-yet-available producer data (load-use).
- Latches resolved operands so they survive producers retiring while EXE back-pressures. Supports flush and keeps a saturating hazard-stall counter.

Parameters:
- PAYLOAD_W, 128: width of opaque decoded payload (alu_op, imm, ctrl, pc…)
- DATA_W, 32: register data width
- ADDR_W, 5: register address width; address 0 is hard-wired zero
- NUM_SRC, 2: operand read ports
- NUM_FWD, 3: producer stages; index 0 = youngest (EXE), highest = oldest (WB)
- CNT_W, 16: stall counter width

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- fs_to_ds_valid  in  1  upstream instruction valid
- fs_payload  in  PAYLOAD_W  upstream payload
- ds_allowin  out  1  stage can accept
- src_addr  in  NUM_SRC*ADDR_W  operand register numbers of the held instruction (from decode of held payload)
- src_used  in  NUM_SRC  operand i actually read
- rf_rdata  in  NUM_SRC*DATA_W  register-file read data
- fwd_we  in  NUM_FWD  producer k valid and writes a register
- fwd_waddr  in  NUM_FWD*ADDR_W  producer destination
- fwd_wdata  in  NUM_FWD*DATA_W  producer result
- fwd_data_ok  in  NUM_FWD  producer result available this cycle (0 for load in EXE)
- es_allowin  in  1  downstream can accept
- flush  in  1  branch/exception cancel
- ds_to_es_valid  out  1  handing instruction downstream
- ds_payload  out  PAYLOAD_W  held payload
- src_data  out  NUM_SRC*DATA_W  resolved operands
- hazard_stall  out  1  current cycle stalled on data hazard
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (async, resetn=0): ds_valid=0, ds_payload=0, hold_valid[*]=0, src_hold=0, stall_cnt=0. Hence ds_to_es_valid=0, ds_allowin=1, hazard_stall=0.
- Operand resolution, per source i:
  - If !src_used[i] or src_addr[i]==0: resolved, value 0.
  - Otherwise find the lowest k with fwd_we[k] && fwd_waddr[k]==src_addr[i]:
    - match with fwd_data_ok[k]=1: resolved, value fwd_wdata[k];
    - match with fwd_data_ok[k]=0: unresolved;
    - no match: resolved, value rf_rdata[i].
  - If hold_valid[i]=1, src_hold[i] overrides all of the above (always resolved).
- ds_ready_go = all sources resolved. hazard_stall = ds_valid && !ds_ready_go.
- ds_to_es_valid = ds_valid && ds_ready_go && !flush.
- ds_allowin = !ds_valid || (ds_ready_go && es_allowin) || flush.
- Accept: on fs_to_ds_valid && ds_allowin && !flush, set ds_valid=1 and load ds_payload. Latency is 1 cycle, fs→ds.
- Flush has priority over accept and hold. Next cycle ds_valid=0 and all hold_valid=0; the payload is don't-care.
- Leave: ds_to_es_valid && es_allowin with no new accept clears ds_valid. Simultaneous leave and accept loads the new payload, ds_valid stays 1.
- Operand hold: when ds_valid && ready_go && !es_allowin, set hold_valid[i]=1 and src_hold[i]=resolved value for each i not already held. Clear all hold_valid on leave, flush or new accept.
- stall_cnt increments every cycle hazard_stall=1 and saturates at all-ones; it is never cleared except by reset.
- Reset mid-stall/hold discards everything. No output may be X after reset.

Decomposition:
- Shared package holds:
  - PIPE_PAYLOAD_W and field offsets for the decoded payload (alu_op, imm, rf_we, rf_waddr, mem ctrl, pc);
  - REG_ZERO = 0;
  - the default NUM_FWD stage indices (FWD_EXE=0, FWD_MEM=1, FWD_WB=2).
- One sub-module is natural: fwd_mux (combinational priority match for one source across NUM_FWD producers, outputs value + resolved). It is instantiated NUM_SRC times via generate.

Test Plan:
- Back-to-back issue: fs_to_ds_valid=1 for 3 cycles with payloads 0x11,0x22,0x33, es_allowin=1 → ds_to_es_valid=1 on cycles 1–3 carrying 0x11,0x22,0x33 in order; ds_allowin stays 1.
- Forward priority: src_addr[0]=5, fwd_we=3'b111, all waddr=5, wdata={WB=0xC,MEM=0xB,EXE=0xA}, data_ok=111 → src_data[0]=0xA. Drop fwd_we[0] → 0xB. Use src_addr=0 → 0.
- Load-use: EXE waddr=7, data_ok[0]=0, src_addr[1]=7 → hazard_stall=1, ds_to_es_valid=0 for 1 cycle, stall_cnt 0→1. Next cycle MEM supplies 0x55 → issues with src_data[1]=0x55.
- Operand hold: ready with WB forwarding 0x99 to r3 while es_allowin=0 for 3 cycles, WB then retires and rf_rdata shows stale 0x0 → on issue, src_data=0x99.
- Flush: flush=1 while holding a stalled instruction and fs_to_ds_valid=1 → same cycle ds_to_es_valid=0; next cycle ds_valid=0, new payload not loaded.
- Async reset: drop resetn mid-hold between clock edges → outputs go to reset values immediately; stall_cnt=0. Saturation check with CNT_W=2: 5 stall cycles → stall_cnt=3.
